// File: rtl/uart_tx_if.sv
// Byte handshake into the uart_tx FIFO.
// The sender holds data_in/valid_in until ready_out is seen high at an edge.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter.
// Bytes queue in a small FIFO and go out LSB first on a registered tx line.
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    uart_tx_if.slave                    bus,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic push;
    logic pop;
    logic bit_end;
    logic tx_next;

    assign bus.ready_out = (count != FULL);
    assign push    = bus.valid_in && bus.ready_out;
    assign pop     = (state == S_IDLE) && (count != '0);
    assign bit_end = (clk_cnt == CNT_LAST);

    assign busy       = (state != S_IDLE) || (count != '0);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tx_next = 1'b1;
        unique case (state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift[bit_idx];
            default: tx_next = 1'b1;
        endcase
    end

    // tx and tx_done trail state by one cycle so the pulse lands on
    // the last stop-bit cycle actually seen on the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_next;
            tx_done <= (state == S_STOP) && bit_end;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises each as 8N1 (one start bit, 8 data bits LSB first, one stop bit) on `tx`. It is the transmit counterpart of the accelerator's UART receive path and returns results and status bytes to the host at the same baud rate.

## Interface
- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division). Must be ≥ 2.
- `FIFO_DEPTH`, 4, byte FIFO entries. Power of 2, ≥ 2.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte to transmit.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  FIFO can accept a byte; equals `count != FIFO_DEPTH`.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high when state ≠ IDLE or the FIFO is non-empty.
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

## Operation
- Push: on a rising edge with `valid_in && ready_out`, write `data_in` at the write pointer. The write pointer wraps modulo `FIFO_DEPTH`. `valid_in` while `ready_out` is low is ignored and the byte is dropped. The sender must hold it.
- `ready_out` is derived from the registered count only. A pop in the same cycle does not raise it combinationally.
- FSM states:
  - IDLE: `tx`=1. If FIFO non-empty, pop head into shift register, clear bit counter and bit index, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=`shift[bit_idx]`, each bit for `CLKS_PER_BIT` cycles, `bit_idx` 0→7. After bit 7 go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On its final cycle pulse `tx_done` and go to IDLE.
- The clock counter is `$clog2(CLKS_PER_BIT)` bits wide. It resets to 0 on every bit boundary and never wraps past `CLKS_PER_BIT-1`.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. A push to an empty FIFO is popped no earlier than the next cycle.
- Reset values (asynchronous, on `reset_n`=0): state IDLE, `tx`=1, `tx_done`=0, `busy`=0, `fifo_count`=0, `ready_out`=1, pointers 0.
- Reset mid-frame aborts the frame with `tx` high immediately, discards all queued bytes, and emits no `tx_done`.

## Timing
- Latency: a byte accepted at edge N into an empty, idle block is popped at edge N+1. `tx` falls after edge N+2, since `tx` is registered from state.
- Frame length: exactly `10*CLKS_PER_BIT` cycles of `tx` from the start-bit fall to the end of the stop bit.
- Back-to-back frames: one IDLE cycle separates frames, so the period is `10*CLKS_PER_BIT + 1` cycles and the line is high for `CLKS_PER_BIT + 1` cycles between frames.
- `tx_done` is high for exactly 1 cycle per frame and coincides with the last stop-bit cycle.
- Throughput: at most one push per cycle. The FIFO absorbs `FIFO_DEPTH` bytes while the line is busy.

## Test plan
Benches use CLK_FREQ=1_000_000 and BAUD_RATE=100_000 (CLKS_PER_BIT=10) unless stated.
- Reset then idle 100 cycles -> `tx`=1, `ready_out`=1, `busy`=0, `fifo_count`=0, no `tx_done`.
- Push 0xA5 once -> `tx` falls 2 cycles after acceptance. Sampling at bit centres gives 0, 1,0,1,0,0,1,0,1, 1. Exactly 100 cycles low-to-stop-end. One `tx_done`.
- Push 0x00, 0xFF, 0x3C, 0x81 in consecutive cycles -> `ready_out` stays high. Four frames in order, start edges 101 cycles apart. Four `tx_done` pulses. `busy` drops after the last.
- Push 6 bytes with `valid_in` held continuously -> the first 5 are accepted (1 shifting + 4 queued). `ready_out` goes low with `fifo_count`=4. The 6th is held until `ready_out` rises one cycle after the next pop. All 6 bytes transmit correctly.
- Assert `reset_n`=0 during bit 3 of 0x55 with 2 bytes queued -> `tx`=1 asynchronously, `fifo_count`=0, no `tx_done`. After release, push 0x12 -> 0x12 is sent normally.
- CLK_FREQ=50_000_000, BAUD_RATE=115200 -> bit period is 434 cycles. Byte 0x7E decodes correctly when sampled at bit centres.
